// File: rtl/slot_scheduler.sv
// Round-robin arbiter that hands one fixed-length timed slot to one requester at a time.
// Grant is registered one edge after a request in IDLE and lasts L cycles; done pulses in the following RELEASE cycle.
// Requests that are not granted are held by the requester and served in round-robin order; the granted requester can abort by dropping its request.
module slot_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_len,
  output logic [NREQ-1:0]   o_grant,
  output logic [W-1:0]      o_val,
  output logic              o_last,
  output logic [NREQ-1:0]   o_done,
  output logic              o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    len_q, len_d;
  logic [W-1:0]    val_q, val_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] rel_q, rel_d;

  logic [NREQ-1:0] arb_req;
  logic            arb_found;
  logic [PW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_onehot;
  logic [W-1:0]    arb_len;
  logic [PW:0]     cand_sum;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_next;
  logic            req_live;
  logic            last;

  // The requester just released sits out the RELEASE-cycle arbitration.
  assign arb_req  = (state_q == S_RELEASE) ? (i_req & ~rel_q) : i_req;
  // The granted requester still wants its slot.
  assign req_live = |(i_req & grant_q);
  assign last     = (state_q == S_RUN) && (val_q == (len_q - W'(1)));
  assign ptr_next = (arb_idx == PW'(NREQ - 1)) ? '0 : (arb_idx + PW'(1));

  // Round-robin search starting at ptr, wrapping modulo NREQ; also picks the winner's length.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    cand_sum   = '0;
    cand       = '0;
    arb_onehot = '0;
    arb_len    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand_sum >= (PW+1)'(NREQ)) begin
        cand_sum = cand_sum - (PW+1)'(NREQ);
      end
      cand = cand_sum[PW-1:0];
      if (!arb_found && arb_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    if (arb_found) begin
      arb_onehot = NREQ'(1) << arb_idx;
    end
    for (int r = 0; r < NREQ; r++) begin
      if (arb_onehot[r]) begin
        arb_len = i_len[r*W +: W];
      end
    end
  end

  // Next-state logic: arbitrate in IDLE/RELEASE, count the slot in RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    val_d   = val_q;
    grant_d = grant_q;
    done_d  = '0;
    rel_d   = rel_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        grant_d = '0;
        val_d   = '0;
        state_d = S_IDLE;
        if (arb_found) begin
          state_d = S_RUN;
          grant_d = arb_onehot;
          len_d   = (arb_len == '0) ? W'(1) : arb_len;
          ptr_d   = ptr_next;
        end
      end
      S_RUN: begin
        if (!req_live) begin
          // Abort wins over a coincident last cycle: no done.
          state_d = S_RELEASE;
          rel_d   = grant_q;
          grant_d = '0;
          val_d   = '0;
        end else if (last) begin
          state_d = S_RELEASE;
          rel_d   = grant_q;
          done_d  = grant_q;
          grant_d = '0;
          val_d   = '0;
        end else begin
          val_d = val_q + W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        val_d   = '0;
      end
    endcase
  end

  // State registers; reset clears grant and done immediately, mid-slot included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      val_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      val_q   <= val_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rel_q   <= rel_d;
    end
  end

  assign o_grant = grant_q;
  assign o_val   = val_q;
  assign o_last  = last;
  assign o_done  = done_q;
  assign o_busy  = |grant_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// Bench for slot_scheduler: directed scenarios plus random requesters against a slot-timeline model.
// Model tracks each slot as (owner, length, start cycle) and a one-cycle release gap.
// Requesters hold requests until their done, with occasional aborts by the slot owner.
module tb_slot_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  i_req;
  logic [15:0] i_len;
  logic [3:0]  o_grant;
  logic [3:0]  o_val;
  logic        o_last;
  logic [3:0]  o_done;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Slot-timeline model state.
  int cyc = 0;
  int m_ptr, m_owner, m_len, m_start, m_done, m_rel_owner;
  bit m_active, m_rel;

  logic [3:0] order_q[$];

  slot_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_len   (i_len),
    .o_grant (o_grant),
    .o_val   (o_val),
    .o_last  (o_last),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_rel       = 1'b0;
    m_ptr       = 0;
    m_owner     = 0;
    m_len       = 0;
    m_start     = 0;
    m_done      = -1;
    m_rel_owner = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples there.
  task automatic model_step();
    int w;
    int r;
    int l;
    w = -1;
    if (!reset_n) begin
      cyc++;
      return;
    end
    if (m_active) begin
      if (!i_req[m_owner]) begin
        m_active = 1'b0; m_rel = 1'b1; m_done = -1; m_rel_owner = m_owner;
      end else if (cyc - m_start == m_len - 1) begin
        m_active = 1'b0; m_rel = 1'b1; m_done = m_owner; m_rel_owner = m_owner;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        r = (m_ptr + k) % NREQ;
        if (w < 0 && i_req[r] && !(m_rel && r == m_rel_owner)) w = r;
      end
      m_rel  = 1'b0;
      m_done = -1;
      if (w >= 0) begin
        l        = int'(i_len[w*4 +: 4]);
        m_active = 1'b1;
        m_owner  = w;
        m_len    = (l == 0) ? 1 : l;
        m_start  = cyc + 1;
        m_ptr    = (w + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    int v;
    v = cyc - m_start;
    check("grant", {28'b0, o_grant}, m_active ? (32'd1 << m_owner) : 32'd0);
    check("val",   {28'b0, o_val},   m_active ? 32'(v) : 32'd0);
    check("last",  {31'b0, o_last},  (m_active && v == m_len - 1) ? 32'd1 : 32'd0);
    check("done",  {28'b0, o_done},  (m_rel && m_done >= 0) ? (32'd1 << m_done) : 32'd0);
    check("busy",  {31'b0, o_busy},  m_active ? 32'd1 : 32'd0);
  endtask

  // One clock: DUT and model take the same edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Hold a request pattern; bits drop on their own done, or on abort after abort_after grant cycles.
  task automatic phase(input logic [3:0] pat, input logic [15:0] lenv, input int n, input int abort_after);
    logic [3:0] dropped;
    dropped = 4'b0;
    i_len   = lenv;
    for (int i = 0; i < n; i++) begin
      if (m_rel && m_done >= 0) dropped[m_done] = 1'b1;
      if (abort_after > 0 && m_active && (cyc - m_start + 1) >= abort_after) dropped[m_owner] = 1'b1;
      i_req = pat & ~dropped;
      tick();
    end
  endtask

  initial begin
    logic [3:0] prev_grant;
    logic [3:0] exp_order [5];
    bit         reached;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held for two cycles with every requester asking.
    model_reset();
    reset_n = 1'b0;
    i_req   = 4'b1111;
    i_len   = 16'h2222;
    @(negedge clk);
    check_outputs();
    tick();
    tick();
    reset_n = 1'b1;

    // Fairness: all lengths 2, each requester drops only on its own done, then re-asks.
    prev_grant = 4'b0;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < NREQ; r++) i_req[r] = !(m_rel && m_done == r);
      tick();
      if (o_grant != 4'b0 && prev_grant == 4'b0) order_q.push_back(o_grant);
      prev_grant = o_grant;
    end
    check("order_cnt", (order_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < order_q.size()) check("order", {28'b0, order_q[k]}, {28'b0, exp_order[k]});
    end

    // Drain to idle.
    phase(4'b0000, 16'h0000, 4, 0);
    // Single request, length 3.
    phase(4'b0010, 16'h0030, 6, 0);
    // Zero length behaves as length 1.
    phase(4'b0100, 16'h0000, 4, 0);
    // Abort after four grant cycles of a length-10 slot.
    phase(4'b0001, 16'h000A, 8, 4);

    // Mid-slot reset at o_val = 7 of a length-15 slot.
    i_req   = 4'b1000;
    i_len   = 16'hF000;
    reached = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (m_active && cyc - m_start == 7) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("rst_reach", {31'b0, reached}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_grant", {28'b0, o_grant}, 32'd0);
    check("rst_busy",  {31'b0, o_busy},  32'd0);
    check("rst_done",  {28'b0, o_done},  32'd0);
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    phase(4'b1000, 16'hF000, 18, 0);

    // Random requesters.
    i_req = 4'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (m_rel && m_done == r) i_req[r] = 1'b0;
        else if (!i_req[r]) i_req[r] = ($urandom_range(0, 3) == 0);
        else if (m_active && m_owner == r && $urandom_range(0, 15) == 0) i_req[r] = 1'b0;
        i_len[r*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 4));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
